// File: rtl/alu_wb_fifo_pkg.sv
// ----------------------------------------------------------------------------
// alu_wb_fifo_pkg
// Shared CPU definitions: datapath word size, ALU function codes, default
// writeback register-index width and a helper that sizes one buffered
// writeback entry ({result, zero, dest}).
// Ports: none (package).
// Related macros: WORD_SIZE (datapath width, 16 unless predefined);
//                 ALU_WB_FIFO_BYPASS_EN is consumed by alu_wb_fifo.
// ----------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package alu_wb_fifo_pkg;

    localparam int WORD_W     = `WORD_SIZE;
    localparam int DEST_W_DEF = 2;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_func_e;

    // Width of one stored entry: result word, zero flag, destination index.
    function automatic int entry_w(input int dest_w);
        return WORD_W + 1 + dest_w;
    endfunction

endpackage

// File: rtl/alu_wb_fifo_mem.sv
// ----------------------------------------------------------------------------
// alu_wb_fifo_mem
// DEPTH x WIDTH storage array for the writeback FIFO: one synchronous write
// port, one asynchronous read port. Contents are never reset; validity is
// tracked by the pointer/count logic in the parent.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  array contents at raddr (combinational read)
// ----------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module alu_wb_fifo_mem
    import alu_wb_fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = WORD_W + 1 + DEST_W_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_wb_fifo.sv
// ----------------------------------------------------------------------------
// alu_wb_fifo
// Buffers ALU results ({result, zero flag, destination index}) on their way
// to register writeback. Valid/ready on both sides, strict FIFO order.
// Optional macro ALU_WB_FIFO_BYPASS_EN: when the FIFO is empty an incoming
// result is presented on out_* in the same cycle; if it is consumed at once
// it is never stored. Without the macro there is no combinational in->out
// path and an entry appears on out_* one cycle after it is pushed.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   synchronous discard of all entries (beats push/pop)
//   in_valid/in_ready       producer handshake; in_ready = !full
//   in_result/in_zero/in_dest  entry fields from the ALU
//   out_valid/out_ready     writeback handshake
//   out_result/out_zero/out_dest  head entry fields (0 while nothing valid)
//   count, full, empty      occupancy
// ----------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module alu_wb_fifo
    import alu_wb_fifo_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DEST_W = DEST_W_DEF,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1,
    localparam int EW     = entry_w(DEST_W)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [`WORD_SIZE-1:0] in_result,
    input  logic                  in_zero,
    input  logic [DEST_W-1:0]     in_dest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [`WORD_SIZE-1:0] out_result,
    output logic                  out_zero,
    output logic [DEST_W-1:0]     out_dest,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          push_acc;
    logic          bypass_take;
    logic          store;
    logic          pop;
    logic [EW-1:0] rd_entry;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign in_ready = !full;
    assign push_acc = in_valid && in_ready;

`ifdef ALU_WB_FIFO_BYPASS_EN
    // Empty FIFO: the incoming result is the head. If writeback takes it in
    // the same cycle it must not also be written into the array.
    assign bypass_take = empty && in_valid && out_ready;
    assign out_valid   = !empty || in_valid;

    always_comb begin
        {out_result, out_zero, out_dest} = '0;
        if (!empty) begin
            {out_result, out_zero, out_dest} = rd_entry;
        end else if (in_valid) begin
            {out_result, out_zero, out_dest} = {in_result, in_zero, in_dest};
        end
    end
`else
    assign bypass_take = 1'b0;
    assign out_valid   = !empty;

    // Gate the array read so stale or never-written storage shows as zero.
    always_comb begin
        {out_result, out_zero, out_dest} = '0;
        if (!empty) begin
            {out_result, out_zero, out_dest} = rd_entry;
        end
    end
`endif

    assign store = push_acc && !bypass_take && !flush;
    assign pop   = !empty && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are AW bits wide, so +1 wraps modulo DEPTH.
            if (store) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(store) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    alu_wb_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q),
        .wdata ({in_result, in_zero, in_dest}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

endmodule

// File: tb/tb_alu_wb_fifo.sv
// ----------------------------------------------------------------------------
// tb_alu_wb_fifo
// Directed scenarios followed by randomized traffic. A queue holds the
// entries the FIFO should currently contain; a separate monitor process
// checks occupancy flags and the head entry every cycle and pops the queue on
// each writeback handshake. Honors ALU_WB_FIFO_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_alu_wb_fifo;

    localparam int DEPTH  = 4;
    localparam int DEST_W = 2;

`ifdef ALU_WB_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [15:0]       r;
        logic              z;
        logic [DEST_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_result = '0;
    logic              in_zero = 1'b0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       out_result;
    logic              out_zero;
    logic [DEST_W-1:0] out_dest;
    logic [2:0]        count;
    logic              full;
    logic              empty;

    alu_wb_fifo #(
        .DEPTH  (DEPTH),
        .DEST_W (DEST_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_zero    (in_zero),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_dest   (out_dest),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ent_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", name, act, want, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   mn;
    bit   mv;
    bit   btake;
    ent_t me;

    always begin
        @(negedge clk);
        #4;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            mn = exp_q.size();
            chk("count",    32'(count),    32'(mn));
            chk("full",     32'(full),     32'(mn == DEPTH));
            chk("empty",    32'(empty),    32'(mn == 0));
            chk("in_ready", 32'(in_ready), 32'(mn < DEPTH));
            mv = 1'b0;
            me = '0;
            if (mn > 0) begin
                mv = 1'b1;
                me = exp_q[0];
            end else if (BYP && in_valid) begin
                mv = 1'b1;
                me = {in_result, in_zero, in_dest};
            end
            chk("out_valid", 32'(out_valid), 32'(mv));
            if (mv) begin
                chk("out_result", 32'(out_result), 32'(me.r));
                chk("out_zero",   32'(out_zero),   32'(me.z));
                chk("out_dest",   32'(out_dest),   32'(me.d));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                btake = BYP && (mn == 0) && in_valid && out_ready;
                if (mv && out_ready)
                    $display("pop result=%h zero=%0d dest=%0d%s", me.r, me.z, me.d,
                             btake ? " bypass" : "");
                if (mn > 0 && out_ready)
                    void'(exp_q.pop_front());
                if (in_valid && mn < DEPTH && !btake)
                    exp_q.push_back({in_result, in_zero, in_dest});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit r, input logic [15:0] res,
                         input bit z, input logic [DEST_W-1:0] d, input bit fl);
        @(negedge clk);
        in_valid  = v;
        out_ready = r;
        in_result = res;
        in_zero   = z;
        in_dest   = d;
        flush     = fl;
    endtask

    task automatic drain();
        repeat (DEPTH + 2) drive(1'b0, 1'b1, 16'h0, 1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"},  32'(out_valid),  32'(0));
        chk({tag, "_count"},      32'(count),      32'(0));
        chk({tag, "_empty"},      32'(empty),      32'(1));
        chk({tag, "_full"},       32'(full),       32'(0));
        chk({tag, "_in_ready"},   32'(in_ready),   32'(1));
        chk({tag, "_out_result"}, 32'(out_result), 32'(0));
        chk({tag, "_out_zero"},   32'(out_zero),   32'(0));
        chk({tag, "_out_dest"},   32'(out_dest),   32'(0));
    endtask

    initial begin
        // Power-on reset
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Single push, head visible the next cycle with out_ready low
        drive(1'b1, 1'b0, 16'h1234, 1'b0, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b0);
        drain();

        // Push into empty FIFO with writeback ready (fall-through case when enabled)
        drive(1'b1, 1'b1, 16'hBEEF, 1'b1, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        drain();

        // Fill to full, hold a fifth push until a pop frees a slot
        for (int i = 1; i <= 4; i++)
            drive(1'b1, 1'b0, 16'(i), 1'b0, 2'(i), 1'b0);
        drive(1'b1, 1'b0, 16'h0005, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 16'h0005, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 1'b1, 16'h0005, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 16'h0005, 1'b1, 2'd1, 1'b0);
        drain();

        // Steady push+pop at count=2 across several pointer wraps
        drive(1'b1, 1'b0, 16'h0100, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 16'h0101, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b1, 16'(16'h0200 + i), 1'(i), 2'(i), 1'b0);
        drain();

        // Flush at count=3 with a simultaneous push
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 16'(16'h0300 + i), 1'b0, 2'(i), 1'b0);
        drive(1'b1, 1'b1, 16'hDEAD, 1'b0, 2'd3, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        drain();

        // Asynchronous reset mid-stream at count=3
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 16'(16'h0400 + i), 1'b0, 2'(i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b0);

        // Randomized traffic: first producer-heavy, then consumer-heavy
        repeat (200)
            drive(($urandom % 4) != 0, ($urandom % 3) == 0, 16'($urandom),
                  1'($urandom), 2'($urandom), ($urandom % 40) == 0);
        repeat (200)
            drive(($urandom % 3) == 0, ($urandom % 4) != 0, 16'($urandom),
                  1'($urandom), 2'($urandom), ($urandom % 40) == 0);
        drain();

        @(negedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
